// File: rtl/iob_reset_seq.sv
// Reset/bring-up sequencer: filters masked ready sources, then releases N_DOM reset
// domains in index order, with bring-up timeout, software reset and ready-loss counting.
module iob_reset_seq #(
    parameter int unsigned N_SRC          = 2,
    parameter int unsigned N_DOM          = 3,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned STEP_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             sw_rst_i,
    input  logic [N_SRC-1:0] ready_i,
    input  logic [N_SRC-1:0] ready_mask_i,
    output logic [N_DOM-1:0] rst_o,
    output logic             all_released_o,
    output logic             timeout_o,
    output logic [2:0]       state_o,
    output logic [7:0]       loss_cnt_o
);

    localparam int unsigned IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        StReset     = 3'd0,
        StWaitReady = 3'd1,
        StStable    = 3'd2,
        StRelease   = 3'd3,
        StRun       = 3'd4,
        StFault     = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic [CNT_W-1:0]   scnt_q, scnt_d;
    logic [CNT_W-1:0]   stepcnt_q, stepcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         loss_q, loss_d;
    logic [N_DOM-1:0]   rst_q, rst_d;
    logic               all_released_q, all_released_d;
    logic               timeout_q, timeout_d;
    logic               all_ok;

    assign all_ok = &(ready_i | ready_mask_i);

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q        <= StReset;
            tcnt_q         <= '0;
            scnt_q         <= '0;
            stepcnt_q      <= '0;
            idx_q          <= '0;
            loss_q         <= '0;
            rst_q          <= '1;
            all_released_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tcnt_q         <= tcnt_d;
            scnt_q         <= scnt_d;
            stepcnt_q      <= stepcnt_d;
            idx_q          <= idx_d;
            loss_q         <= loss_d;
            rst_q          <= rst_d;
            all_released_q <= all_released_d;
            timeout_q      <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        scnt_d    = scnt_q;
        stepcnt_d = stepcnt_q;
        idx_d     = idx_q;
        loss_d    = loss_q;
        if (sw_rst_i) begin
            state_d   = StReset;
            tcnt_d    = '0;
            scnt_d    = '0;
            stepcnt_d = '0;
            idx_d     = '0;
        end else begin
            unique case (state_q)
                StReset: begin
                    state_d = StWaitReady;
                    tcnt_d  = '0;
                end
                StWaitReady: begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                    if (all_ok) begin
                        state_d = StStable;
                        scnt_d  = '0;
                    end else if (tcnt_q >= TCNT_LAST) begin
                        state_d = StFault;
                    end
                end
                StStable: begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                    if (!all_ok) begin
                        state_d = StWaitReady;
                    end else if (scnt_q == SCNT_LAST) begin
                        // Stable completion wins over a coincident timeout.
                        if (N_DOM == 1) state_d = StRun;
                        else            state_d = StRelease;
                        idx_d     = '0;
                        stepcnt_d = '0;
                    end else begin
                        scnt_d = scnt_q + CNT_W'(1);
                        if (tcnt_q >= TCNT_LAST) state_d = StFault;
                    end
                end
                StRelease, StRun: begin
                    if (!all_ok) begin
                        state_d   = StWaitReady;
                        tcnt_d    = '0;
                        scnt_d    = '0;
                        stepcnt_d = '0;
                        idx_d     = '0;
                        if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
                    end else if (state_q == StRelease) begin
                        if (stepcnt_q == STEP_LAST) begin
                            stepcnt_d = '0;
                            if (32'(idx_q) + 32'd2 == N_DOM) state_d = StRun;
                            else                             idx_d = idx_q + IDX_W'(1);
                        end else begin
                            stepcnt_d = stepcnt_q + CNT_W'(1);
                        end
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StReset;
                end
            endcase
        end
    end

    // Domain k is out of reset once idx has reached it, which keeps release order monotonic.
    always_comb begin
        rst_d = '1;
        for (int k = 0; k < int'(N_DOM); k++) begin
            rst_d[k] = !((state_d == StRun) ||
                         ((state_d == StRelease) && (k <= int'(idx_d))));
        end
        all_released_d = (state_d == StRun);
        timeout_d      = (state_d == StFault);
    end

    assign rst_o          = rst_q;
    assign all_released_o = all_released_q;
    assign timeout_o      = timeout_q;
    assign state_o        = state_q;
    assign loss_cnt_o     = loss_q;

endmodule

// File: tb/tb_iob_reset_seq.sv
// Directed bench for iob_reset_seq: default instance for sequencing, loss, mask and resets;
// a second instance with a short timeout for the fault path.
module tb_iob_reset_seq;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       resetn_a = 1'b0, sw_a = 1'b0;
    logic [1:0] ready_a = 2'b00, mask_a = 2'b00;
    logic [2:0] rst_a;
    logic       allrel_a, to_a;
    logic [2:0] state_a;
    logic [7:0] loss_a;

    logic       resetn_b = 1'b0, sw_b = 1'b0;
    logic [1:0] ready_b = 2'b00, mask_b = 2'b00;
    logic [2:0] rst_b;
    logic       allrel_b, to_b;
    logic [2:0] state_b;
    logic [7:0] loss_b;

    always #5 clk = ~clk;

    iob_reset_seq u_dut_a (
        .clk_i          (clk),
        .resetn_i       (resetn_a),
        .sw_rst_i       (sw_a),
        .ready_i        (ready_a),
        .ready_mask_i   (mask_a),
        .rst_o          (rst_a),
        .all_released_o (allrel_a),
        .timeout_o      (to_a),
        .state_o        (state_a),
        .loss_cnt_o     (loss_a)
    );

    iob_reset_seq #(.TIMEOUT_CYCLES(100)) u_dut_b (
        .clk_i          (clk),
        .resetn_i       (resetn_b),
        .sw_rst_i       (sw_b),
        .ready_i        (ready_b),
        .ready_mask_i   (mask_b),
        .rst_o          (rst_b),
        .all_released_o (allrel_b),
        .timeout_o      (to_b),
        .state_o        (state_b),
        .loss_cnt_o     (loss_b)
    );

    // Cycle n starts at posedge n; inputs set here are sampled at posedge n+1.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        int d;
        // Power-on reset, cycles 0-2
        goto(3);
        chk("rst_reset", 32'(rst_a), 32'h7);
        chk("allrel_reset", 32'(allrel_a), 32'h0);
        chk("timeout_reset", 32'(to_a), 32'h0);
        chk("state_reset", 32'(state_a), 32'h0);
        chk("loss_reset", 32'(loss_a), 32'h0);
        resetn_a = 1'b1;
        goto(4);
        chk("state_wait", 32'(state_a), 32'h1);

        // Nominal bring-up
        goto(10); ready_a = 2'b11;
        goto(11); chk("state_stable", 32'(state_a), 32'h2);
        goto(26); chk("rst_pre_rel0", 32'(rst_a), 32'h7);
        goto(27); chk("rst_rel0", 32'(rst_a), 32'h6);
                  chk("state_release", 32'(state_a), 32'h3);
        goto(34); chk("rst_pre_rel1", 32'(rst_a), 32'h6);
        goto(35); chk("rst_rel1", 32'(rst_a), 32'h4);
        goto(42); chk("allrel_pre", 32'(allrel_a), 32'h0);
        goto(43); chk("rst_rel2", 32'(rst_a), 32'h0);
                  chk("allrel_run", 32'(allrel_a), 32'h1);
                  chk("state_run", 32'(state_a), 32'h4);
                  chk("loss_run", 32'(loss_a), 32'h0);

        // Loss in RUN, then re-sequence with identical spacing
        goto(50); ready_a = 2'b10;
        goto(51); ready_a = 2'b11;
                  chk("rst_loss", 32'(rst_a), 32'h7);
                  chk("allrel_loss", 32'(allrel_a), 32'h0);
                  chk("state_loss", 32'(state_a), 32'h1);
                  chk("loss_one", 32'(loss_a), 32'h1);
        goto(67); chk("rst_reseq_pre", 32'(rst_a), 32'h7);
        goto(68); chk("rst_reseq0", 32'(rst_a), 32'h6);
        goto(76); chk("rst_reseq1", 32'(rst_a), 32'h4);
        goto(84); chk("rst_reseq2", 32'(rst_a), 32'h0);
                  chk("allrel_reseq", 32'(allrel_a), 32'h1);

        // Software reset held two cycles from RUN
        goto(90); sw_a = 1'b1;
        goto(91); chk("state_sw", 32'(state_a), 32'h0);
                  chk("rst_sw", 32'(rst_a), 32'h7);
                  chk("loss_sw_kept", 32'(loss_a), 32'h1);
        goto(92); chk("state_sw_held", 32'(state_a), 32'h0);
                  sw_a = 1'b0; ready_a = 2'b00;
        goto(93); chk("state_after_sw", 32'(state_a), 32'h1);

        // Glitch filter: ready_i[1] drops for one cycle during STABLE
        goto(100); ready_a = 2'b11;
        goto(101); chk("state_glitch_stable", 32'(state_a), 32'h2);
        goto(110); ready_a = 2'b01;
        goto(111); ready_a = 2'b11;
                   chk("state_glitch_wait", 32'(state_a), 32'h1);
                   chk("loss_glitch", 32'(loss_a), 32'h1);
        goto(117); chk("rst_glitch_mid", 32'(rst_a), 32'h7);
        goto(127); chk("rst_glitch_pre", 32'(rst_a), 32'h7);
        goto(128); chk("rst_glitch_rel0", 32'(rst_a), 32'h6);

        // Software reset mid-release
        goto(130); sw_a = 1'b1;
        goto(131); sw_a = 1'b0;
                   chk("rst_sw_midrel", 32'(rst_a), 32'h7);
                   chk("state_sw_midrel", 32'(state_a), 32'h0);
        goto(132); chk("state_sw_midrel_wait", 32'(state_a), 32'h1);
        goto(149); chk("rst_after_midrel", 32'(rst_a), 32'h6);

        // 300 losses during RELEASE; counter saturates
        d = 150;
        for (int i = 0; i < 300; i++) begin
            goto(d); ready_a = 2'b10;
            goto(d + 1); ready_a = 2'b11;
            if (i == 0) chk("loss_in_release", 32'(loss_a), 32'h2);
            d += 18;
        end
        chk("loss_sat", 32'(loss_a), 32'hff);
        chk("state_sat", 32'(state_a), 32'h1);
        goto(5566); chk("allrel_sat", 32'(allrel_a), 32'h1);
                    chk("loss_sat_run", 32'(loss_a), 32'hff);

        // Hard reset from RUN
        goto(5570); resetn_a = 1'b0;
        goto(5571); chk("rst_hard", 32'(rst_a), 32'h7);
                    chk("state_hard", 32'(state_a), 32'h0);
                    chk("loss_hard", 32'(loss_a), 32'h0);
                    chk("allrel_hard", 32'(allrel_a), 32'h0);
                    resetn_a = 1'b1; ready_a = 2'b00; mask_a = 2'b10;

        // Mask: ready_i[1] ignored
        goto(5580); ready_a = 2'b01;
        goto(5596); chk("rst_mask_pre", 32'(rst_a), 32'h7);
        goto(5597); chk("rst_mask0", 32'(rst_a), 32'h6);
        goto(5605); chk("rst_mask1", 32'(rst_a), 32'h4);
        goto(5613); chk("rst_mask2", 32'(rst_a), 32'h0);
                    chk("allrel_mask", 32'(allrel_a), 32'h1);

        // Timeout on the short-timeout instance
        goto(5620); chk("b_state_reset", 32'(state_b), 32'h0);
                    resetn_b = 1'b1;
        goto(5621); chk("b_state_wait", 32'(state_b), 32'h1);
        goto(5720); chk("b_state_pre_to", 32'(state_b), 32'h1);
                    chk("b_to_pre", 32'(to_b), 32'h0);
        goto(5721); chk("b_state_fault", 32'(state_b), 32'h5);
                    chk("b_to_fault", 32'(to_b), 32'h1);
                    chk("b_rst_fault", 32'(rst_b), 32'h7);
        goto(5730); ready_b = 2'b11;
        goto(5740); chk("b_state_fault_held", 32'(state_b), 32'h5);
                    chk("b_rst_fault_held", 32'(rst_b), 32'h7);
                    chk("b_loss_fault", 32'(loss_b), 32'h0);
        goto(5745); sw_b = 1'b1;
        goto(5746); sw_b = 1'b0;
                    chk("b_state_sw", 32'(state_b), 32'h0);
                    chk("b_to_cleared", 32'(to_b), 32'h0);
        goto(5747); chk("b_state_wait2", 32'(state_b), 32'h1);
        goto(5764); chk("b_rst_rel0", 32'(rst_b), 32'h6);
                    chk("b_to_after", 32'(to_b), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
